// File: rtl/rgb_fade_pkg.sv
// Shared types and helpers for the RGB fade sequencer.
// Optional gamma publish mapping is selected by the RGB_FADE_GAMMA_EN macro.
package rgb_fade_pkg;

    localparam int DUTY_W = 8;
    localparam int TICK_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2
    } fade_state_e;

    typedef struct packed {
        logic [3*DUTY_W-1:0] rgb;
        logic [TICK_W-1:0]   step;
        logic [TICK_W-1:0]   hold;
    } fade_cmd_t;

    localparam int CMD_W = $bits(fade_cmd_t);

    // One-LSB move toward the target; never overshoots, so no wrap is possible.
    function automatic logic [DUTY_W-1:0] ramp_step(input logic [DUTY_W-1:0] cur,
                                                    input logic [DUTY_W-1:0] tgt);
        logic [DUTY_W-1:0] res;
        if (cur < tgt) begin
            res = cur + DUTY_W'(1);
        end else if (cur > tgt) begin
            res = cur - DUTY_W'(1);
        end else begin
            res = cur;
        end
        return res;
    endfunction

    function automatic logic [DUTY_W-1:0] duty_map(input logic [DUTY_W-1:0] c);
`ifdef RGB_FADE_GAMMA_EN
        logic [2*DUTY_W:0] sq;
        sq = ({{(DUTY_W+1){1'b0}}, c} * {{(DUTY_W+1){1'b0}}, c})
             + {{(DUTY_W+1){1'b0}}, {DUTY_W{1'b1}}};
        return sq[2*DUTY_W-1:DUTY_W];
`else
        return c;
`endif
    endfunction

endpackage

// File: rtl/rgb_fade_sequencer_if.sv
// Command handshake between a fade requester (master) and the sequencer (slave).
interface rgb_fade_sequencer_if;
    import rgb_fade_pkg::*;

    logic                cmd_valid;
    logic                cmd_ready;
    logic [3*DUTY_W-1:0] cmd_rgb;
    logic [TICK_W-1:0]   cmd_step;
    logic [TICK_W-1:0]   cmd_hold;

    modport master (output cmd_valid, output cmd_rgb, output cmd_step, output cmd_hold,
                    input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_rgb, input  cmd_step, input  cmd_hold,
                    output cmd_ready);

endinterface

// File: rtl/rgb_fade_cmd_fifo.sv
// Synchronous command FIFO with registered occupancy; full/empty decode straight from level.
module rgb_fade_cmd_fifo
    import rgb_fade_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  fade_cmd_t                wdata_i,
    output fade_cmd_t                rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    fade_cmd_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_o    = (level_q == LVL_W'(DEPTH));
    assign empty_o   = (level_q == LVL_W'(0));
    assign level_o   = level_q;
    assign rdata_o   = mem_q[rd_ptr_q];
    assign push_ok_s = push_i && !full_o;
    assign pop_ok_s  = pop_i && !empty_o;

    // Storage write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Fade sequencer: ramps per-channel duty toward queued targets and publishes on PWM frame ends.
// Define RGB_FADE_GAMMA_EN to publish gamma-mapped duty instead of linear duty.
module rgb_fade_sequencer
    import rgb_fade_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    rgb_fade_sequencer_if.slave          cmd_if,
    input  logic                         frame_done_i,
    output logic [DUTY_W-1:0]            duty_r_o,
    output logic [DUTY_W-1:0]            duty_g_o,
    output logic [DUTY_W-1:0]            duty_b_o,
    output logic                         duty_load_o,
    output logic                         busy_o,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level_o
);
    localparam int RGB_W = 3 * DUTY_W;

    fade_state_e       state_q, state_d;
    logic [RGB_W-1:0]  tgt_q, tgt_d;
    logic [RGB_W-1:0]  cur_q, cur_d;
    logic [RGB_W-1:0]  duty_q, duty_d;
    logic [RGB_W-1:0]  map_s;
    logic [TICK_W-1:0] step_q, step_d;
    logic [TICK_W-1:0] hold_q, hold_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [TICK_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [TICK_W-1:0] step_last_s;
    logic              load_q, load_d;
    logic              pop_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    fade_cmd_t         push_cmd_s;
    fade_cmd_t         head_cmd_s;

    assign push_cmd_s = '{rgb: cmd_if.cmd_rgb, step: cmd_if.cmd_step, hold: cmd_if.cmd_hold};

    rgb_fade_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (cmd_if.cmd_valid),
        .pop_i   (pop_s),
        .wdata_i (push_cmd_s),
        .rdata_o (head_cmd_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .level_o (fifo_level_o)
    );

    assign cmd_if.cmd_ready = !fifo_full_s;
    assign busy_o           = (state_q != IDLE) || !fifo_empty_s;
    assign step_last_s      = (step_q == TICK_W'(0)) ? TICK_W'(0) : (step_q - TICK_W'(1));

    // FSM next-state, ramp stepping and command fetch
    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        cur_d      = cur_q;
        step_d     = step_q;
        hold_d     = hold_q;
        tick_d     = tick_q;
        hold_cnt_d = hold_cnt_q;
        pop_s      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    tgt_d   = head_cmd_s.rgb;
                    step_d  = head_cmd_s.step;
                    hold_d  = head_cmd_s.hold;
                    tick_d  = TICK_W'(0);
                    state_d = RAMP;
                end else begin
                    state_d = IDLE;
                end
            end
            RAMP: begin
                // Arrival is tested before stepping, so a target equal to cur exits at once
                if (cur_q == tgt_q) begin
                    hold_cnt_d = TICK_W'(0);
                    state_d    = HOLD;
                end else if (tick_q == step_last_s) begin
                    tick_d = TICK_W'(0);
                    for (int i = 0; i < 3; i++) begin
                        cur_d[i*DUTY_W +: DUTY_W] = ramp_step(cur_q[i*DUTY_W +: DUTY_W],
                                                              tgt_q[i*DUTY_W +: DUTY_W]);
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            HOLD: begin
                if (hold_cnt_q >= hold_q) begin
                    state_d = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + TICK_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Publish decision: only at frame end and only when the mapped duty actually differs
    always_comb begin
        map_s = '0;
        for (int i = 0; i < 3; i++) begin
            map_s[i*DUTY_W +: DUTY_W] = duty_map(cur_q[i*DUTY_W +: DUTY_W]);
        end
        duty_d = duty_q;
        if (frame_done_i && (map_s != duty_q)) begin
            duty_d = map_s;
            load_d = 1'b1;
        end else begin
            load_d = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tgt_q      <= '0;
            cur_q      <= '0;
            step_q     <= '0;
            hold_q     <= '0;
            tick_q     <= '0;
            hold_cnt_q <= '0;
            duty_q     <= '0;
            load_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            cur_q      <= cur_d;
            step_q     <= step_d;
            hold_q     <= hold_d;
            tick_q     <= tick_d;
            hold_cnt_q <= hold_cnt_d;
            duty_q     <= duty_d;
            load_q     <= load_d;
        end
    end

    assign duty_r_o    = duty_q[3*DUTY_W-1:2*DUTY_W];
    assign duty_g_o    = duty_q[2*DUTY_W-1:DUTY_W];
    assign duty_b_o    = duty_q[DUTY_W-1:0];
    assign duty_load_o = load_q;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Bench for rgb_fade_sequencer: directed vector table plus random traffic against a timeline model.
module tb_rgb_fade_sequencer;
    import rgb_fade_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_done;
    logic [7:0] duty_r, duty_g, duty_b;
    logic       duty_load, busy;
    logic [2:0] fifo_level;

    rgb_fade_sequencer_if cmd_if();

    rgb_fade_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_if       (cmd_if),
        .frame_done_i (frame_done),
        .duty_r_o     (duty_r),
        .duty_g_o     (duty_g),
        .duty_b_o     (duty_b),
        .duty_load_o  (duty_load),
        .busy_o       (busy),
        .fifo_level_o (fifo_level)
    );

    always #5 clk = ~clk;

    // Each accepted command occupies a fixed window of clock edges computed from its distance.
    typedef struct {
        logic [23:0] rgb;
        logic [23:0] sv;
        int          s;
        int          h;
        int          push_e;
        int          start_e;
        int          end_e;
    } mcmd_t;

    typedef struct {
        logic [23:0] rgb;
        logic [15:0] step;
        logic [15:0] hold;
        int          fd_per;
        bit          sum_ff;
        int          exp_cycles;
    } vec_t;

    mcmd_t       mq[$];
    int          edge_n;
    int          n_tests;
    int          n_fail;
    logic [23:0] exp_duty;
    bit          exp_load;

    function automatic logic [7:0] map8(input logic [7:0] c);
`ifdef RGB_FADE_GAMMA_EN
        int v;
        v = (int'(c) * int'(c) + 255) >> 8;
        return 8'(v);
`else
        return c;
`endif
    endfunction

    function automatic logic [23:0] map24(input logic [23:0] v);
        return {map8(v[23:16]), map8(v[15:8]), map8(v[7:0])};
    endfunction

    function automatic logic [23:0] cur_of(input mcmd_t m, input int e);
        logic [23:0] r;
        int sv, tv, n, mag;
        r = m.sv;
        for (int c = 0; c < 3; c++) begin
            sv  = int'(m.sv[c*8 +: 8]);
            tv  = int'(m.rgb[c*8 +: 8]);
            n   = (e - m.start_e) / m.s;
            mag = (tv > sv) ? tv - sv : sv - tv;
            if (n > mag) n = mag;
            r[c*8 +: 8] = 8'((tv >= sv) ? sv + n : sv - n);
        end
        return r;
    endfunction

    function automatic logic [23:0] cur_at(input int e);
        logic [23:0] r;
        r = 24'h0;
        foreach (mq[i]) if (mq[i].start_e <= e) r = cur_of(mq[i], e);
        return r;
    endfunction

    function automatic int lvl_at(input int e);
        int cnt;
        cnt = 0;
        foreach (mq[i]) if (mq[i].push_e <= e && mq[i].start_e > e) cnt++;
        return cnt;
    endfunction

    function automatic bit busy_at(input int e);
        bit b;
        b = (lvl_at(e) > 0);
        foreach (mq[i]) if (mq[i].start_e <= e && e < mq[i].end_e) b = 1'b1;
        return b;
    endfunction

    function automatic void add_cmd(input logic [23:0] rgb, input int s, input int h, input int p);
        mcmd_t m;
        int prev_end, d, diff;
        m.rgb    = rgb;
        m.s      = s;
        m.h      = h;
        m.push_e = p;
        m.sv     = (mq.size() > 0) ? mq[$].rgb : 24'h0;
        prev_end = (mq.size() > 0) ? mq[$].end_e : -1;
        m.start_e = (p + 1 > prev_end + 1) ? p + 1 : prev_end + 1;
        d = 0;
        for (int c = 0; c < 3; c++) begin
            diff = int'(rgb[c*8 +: 8]) - int'(m.sv[c*8 +: 8]);
            if (diff < 0) diff = -diff;
            if (diff > d) d = diff;
        end
        m.end_e = m.start_e + d * s + h + 2;
        mq.push_back(m);
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", nm, edge_n, act, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, then compare every output.
    task automatic step_cycle(input bit fd, input bit pv, input logic [23:0] rgb,
                              input logic [15:0] st, input logic [15:0] hd, output bit acc);
        logic [23:0] pub;
        acc = pv && (lvl_at(edge_n) < DEPTH);
        cmd_if.cmd_valid = pv;
        cmd_if.cmd_rgb   = rgb;
        cmd_if.cmd_step  = st;
        cmd_if.cmd_hold  = hd;
        frame_done       = fd;
        @(posedge clk);
        edge_n++;
        if (acc) add_cmd(rgb, (st == 16'd0) ? 1 : int'(st), int'(hd), edge_n);
        if (fd) begin
            pub = map24(cur_at(edge_n - 1));
            if (pub != exp_duty) begin
                exp_duty = pub;
                exp_load = 1'b1;
            end else begin
                exp_load = 1'b0;
            end
        end else begin
            exp_load = 1'b0;
        end
        #1;
        cmd_if.cmd_valid = 1'b0;
        frame_done       = 1'b0;
        chk("duty",       longint'({duty_r, duty_g, duty_b}), longint'(exp_duty));
        chk("duty_load",  longint'(duty_load), longint'(exp_load));
        chk("busy",       longint'(busy), longint'(busy_at(edge_n)));
        chk("fifo_level", longint'(fifo_level), longint'(lvl_at(edge_n)));
        chk("cmd_ready",  longint'(cmd_if.cmd_ready), longint'(lvl_at(edge_n) < DEPTH));
    endtask

    task automatic run_until_idle(input int budget, output int cyc);
        bit a;
        cyc = 0;
        while (busy && cyc < budget) begin
            cyc++;
            step_cycle(($urandom_range(0, 3) == 0), 1'b0, 24'h0, 16'd0, 16'd0, a);
        end
        chk("drain_idle", longint'(busy), 0);
    endtask

    vec_t vt[5];
    bit   acc;
    int   cyc;
    bit   done;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        edge_n  = 0;
        exp_duty = 24'h0;
        exp_load = 1'b0;
        rst_n = 1'b0;
        frame_done = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_rgb   = 24'h0;
        cmd_if.cmd_step  = 16'd0;
        cmd_if.cmd_hold  = 16'd0;

        vt[0] = '{24'hFF0000, 16'd1, 16'd0, 16, 1'b0, 258};
        vt[1] = '{24'h00FF00, 16'd4, 16'd0, 1,  1'b1, 1023};
        vt[2] = '{24'h00FF00, 16'd0, 16'd3, 5,  1'b0, 6};
        vt[3] = '{24'h03FF00, 16'd0, 16'd2, 3,  1'b0, 8};
        vt[4] = '{24'h10F005, 16'd2, 16'd1, 7,  1'b0, 34};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_duty",  longint'({duty_r, duty_g, duty_b}), 0);
        chk("rst_load",  longint'(duty_load), 0);
        chk("rst_busy",  longint'(busy), 0);
        chk("rst_level", longint'(fifo_level), 0);
        chk("rst_ready", longint'(cmd_if.cmd_ready), 1);
        rst_n = 1'b1;

        // Directed fades: completion time, final published duty, ramp symmetry
        for (int i = 0; i < 5; i++) begin
            step_cycle(1'b0, 1'b1, vt[i].rgb, vt[i].step, vt[i].hold, acc);
            cyc  = 0;
            done = 1'b0;
            while (!done && cyc < 3000) begin
                cyc++;
                step_cycle((cyc % vt[i].fd_per) == 0, 1'b0, 24'h0, 16'd0, 16'd0, acc);
`ifndef RGB_FADE_GAMMA_EN
                if (vt[i].sum_ff && duty_load)
                    chk("r_plus_g", longint'(int'(duty_r) + int'(duty_g)), 255);
`endif
                if (!busy) done = 1'b1;
            end
            chk("fade_cycles", longint'(cyc), longint'(vt[i].exp_cycles));
            step_cycle(1'b1, 1'b0, 24'h0, 16'd0, 16'd0, acc);
            chk("final_duty", longint'({duty_r, duty_g, duty_b}), longint'(map24(vt[i].rgb)));
        end

        // FIFO back-pressure while the sequencer sits in a long hold
        step_cycle(1'b0, 1'b1, 24'h10F005, 16'd1, 16'd512, acc);
        for (int i = 0; i < 4; i++) step_cycle(1'b0, 1'b1, 24'h10F005, 16'd0, 16'd0, acc);
        chk("full_ready", longint'(cmd_if.cmd_ready), 0);
        chk("full_level", longint'(fifo_level), 4);
        cyc = 0;
        acc = 1'b0;
        while (!acc && cyc < 1000) begin
            cyc++;
            step_cycle(1'b0, 1'b1, 24'h10F005, 16'd0, 16'd0, acc);
        end
        chk("accept_after_pop", longint'(acc), 1);
        chk("accept_wait_long", longint'(cyc > 500), 1);
        for (int i = 0; i < 12; i++) step_cycle(1'b0, 1'b1, 24'h10F005, 16'd0, 16'd0, acc);
        run_until_idle(3000, cyc);

        // Asynchronous reset in the middle of a ramp with commands still queued
        step_cycle(1'b0, 1'b1, 24'hFF0000, 16'd1, 16'd0, acc);
        step_cycle(1'b1, 1'b1, 24'h00FF00, 16'd1, 16'd0, acc);
        step_cycle(1'b1, 1'b1, 24'h0000FF, 16'd1, 16'd0, acc);
        for (int i = 0; i < 47; i++) step_cycle(1'b1, 1'b0, 24'h0, 16'd0, 16'd0, acc);
        chk("pre_rst_r", longint'(duty_r), 8'h3F);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_duty",  longint'({duty_r, duty_g, duty_b}), 0);
        chk("arst_level", longint'(fifo_level), 0);
        chk("arst_busy",  longint'(busy), 0);
        chk("arst_ready", longint'(cmd_if.cmd_ready), 1);
        @(posedge clk);
        edge_n++;
        #1;
        rst_n = 1'b1;
        mq.delete();
        exp_duty = 24'h0;
        exp_load = 1'b0;
        for (int i = 0; i < 20; i++) step_cycle(1'b1, 1'b0, 24'h0, 16'd0, 16'd0, acc);

        // Random traffic against the timeline model
        for (int i = 0; i < 6000; i++) begin
            step_cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0),
                       24'($urandom), 16'($urandom_range(0, 3)), 16'($urandom_range(0, 5)), acc);
        end
        run_until_idle(12000, cyc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
